processor: RTL and testbench

- 8-bit multi-cycle accumulator processor with an 11-bit instruction word (8-bit operand, 3-bit opcode).
- Reads instructions combinationally from an external memory indexed by `pc`.
- Exposes its FSM state so the memory wrapper can write results back.
- `state[2]` is the writeback strobe: on its rising edge the wrapper writes `out` into the operand field `[10:3]` of the word at `pc`.

---
 rtl/processor.sv | 147 ++++++++++++++
 tb/tb_processor.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor.sv
// rtl/processor.sv - 8-bit multi-cycle accumulator processor with one-hot FSM and writeback strobe
//
// Purpose:
//    Fetches an 11-bit instruction {imm[7:0], op[2:0]} from external memory at pc,
//    then executes it on accumulator A and auxiliary register B. STORE adds a WB
//    cycle; during that cycle the memory wrapper writes out into the operand field
//    [10:3] of mem[pc].
//
// Ports:
//    clk    input   1   system clock, rising edge
//    rst_n  input   1   asynchronous active-low reset
//    instr  input  11   instruction at mem[pc]: [10:3] imm, [2:0] opcode
//    pc     output  8   program counter (registered)
//    state  output  3   one-hot FSM state: 001 FETCH, 010 EXEC, 100 WB, 000 in reset
//    out    output  8   register A
//
// Build option:
//    SAT_ARITH_EN - when defined, ADD saturates at 8'hFF and SUB clamps at 8'h00;
//                   otherwise both wrap modulo 256.

module processor #(
   parameter logic [7:0] RESET_PC  = 8'h00,
   parameter logic [7:0] RESET_ACC = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] instr,
   output logic [7:0]  pc,
   output logic [2:0]  state,
   output logic [7:0]  out
);

   typedef enum logic [2:0] {
      ST_RESET = 3'b000,
      ST_FETCH = 3'b001,
      ST_EXEC  = 3'b010,
      ST_WB    = 3'b100
   } state_t;

   typedef enum logic [2:0] {
      OP_STORE = 3'd0,
      OP_ADD   = 3'd1,
      OP_SUB   = 3'd2,
      OP_MOVB  = 3'd3,
      OP_LDA   = 3'd4,
      OP_LDB   = 3'd5,
      OP_JMP   = 3'd6,
      OP_JZ    = 3'd7
   } opcode_t;

   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [10:0] ir_q, ir_d;

   logic [7:0]  imm;
   opcode_t     op;
   logic [7:0]  pc_inc;
   logic [7:0]  add_res;
   logic [7:0]  sub_res;

   assign imm    = ir_q[10:3];
   assign op     = opcode_t'(ir_q[2:0]);
   assign pc_inc = pc_q + 8'd1;

`ifdef SAT_ARITH_EN
   logic [8:0] add_wide;

   always_comb begin
      add_wide = {1'b0, a_q} + {1'b0, b_q};
      add_res  = add_wide[8] ? 8'hFF : add_wide[7:0];
      sub_res  = (a_q < b_q) ? 8'h00 : (a_q - b_q);
   end
`else
   always_comb begin
      add_res = a_q + b_q;
      sub_res = a_q - b_q;
   end
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      a_d     = a_q;
      b_d     = b_q;
      ir_d    = ir_q;

      case (state_q)
         // First edge after reset release only leaves the reset encoding.
         ST_RESET: state_d = ST_FETCH;

         ST_FETCH: begin
            ir_d    = instr;
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
            case (op)
               // pc is held through WB so the wrapper writes back to this word.
               OP_STORE: begin
                  pc_d    = pc_q;
                  state_d = ST_WB;
               end
               OP_ADD:  a_d  = add_res;
               OP_SUB:  a_d  = sub_res;
               OP_MOVB: b_d  = a_q;
               OP_LDA:  a_d  = imm;
               OP_LDB:  b_d  = imm;
               OP_JMP:  pc_d = imm;
               OP_JZ:   pc_d = (a_q == 8'h00) ? imm : pc_inc;
               default: pc_d = pc_inc;
            endcase
         end

         ST_WB: begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
         end

         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         pc_q    <= RESET_PC;
         a_q     <= RESET_ACC;
         b_q     <= RESET_ACC;
         ir_q    <= 11'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ir_q    <= ir_d;
      end
   end

   assign pc    = pc_q;
   assign state = state_q;
   assign out   = a_q;

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - self-checking bench for processor with memory wrapper model and scoreboard

module tb_processor;

   localparam logic [2:0] OP_STORE = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_SUB   = 3'd2;
   localparam logic [2:0] OP_MOVB  = 3'd3;
   localparam logic [2:0] OP_LDA   = 3'd4;
   localparam logic [2:0] OP_LDB   = 3'd5;
   localparam logic [2:0] OP_JMP   = 3'd6;
   localparam logic [2:0] OP_JZ    = 3'd7;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] a;
      int         cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [10:0] instr_w;
   logic [7:0]  dut_pc;
   logic [2:0]  dut_state;
   logic [7:0]  dut_out;

   logic [10:0] mem [256];
   logic        force_en;
   logic [10:0] force_val;

   exp_t sb[$];
   int   n_checks;
   int   n_errors;

   assign instr_w = force_en ? force_val : mem[dut_pc];

   processor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .instr (instr_w),
      .pc    (dut_pc),
      .state (dut_state),
      .out   (dut_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] enc(input logic [2:0] op, input logic [7:0] imm);
      return {imm, op};
   endfunction

   task automatic begin_prog();
      rst_n    = 1'b0;
      force_en = 1'b0;
      force_val = 11'd0;
      sb.delete();
      for (int i = 0; i < 256; i++) mem[i] = 11'd0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Observes one instruction from FETCH back to FETCH; models the wrapper's
   // writeback on the rising edge of state[2].
   task automatic wait_instr(output logic [7:0] pc_o, output logic [7:0] a_o,
                             output int cyc_o, output int wb_o, output bit to_o);
      logic prev_wb;
      cyc_o   = 0;
      wb_o    = 0;
      to_o    = 1'b0;
      prev_wb = dut_state[2];
      forever begin
         @(posedge clk);
         @(negedge clk);
         cyc_o++;
         if (dut_state[2] && !prev_wb) begin
            wb_o++;
            mem[dut_pc][10:3] = dut_out;
         end
         prev_wb = dut_state[2];
         if (dut_state == 3'b001) break;
         if (cyc_o > 8) begin
            to_o = 1'b1;
            break;
         end
      end
      pc_o = dut_pc;
      a_o  = dut_out;
   endtask

   task automatic test_reset();
      logic [7:0] p, a;
      int c, w;
      bit to;
      exp_t e;
      begin_prog();
      mem[0] = enc(OP_LDA, 8'h05);
      mem[1] = enc(OP_LDB, 8'h03);
      mem[2] = enc(OP_LDA, 8'h09);
      #1;
      n_checks++;
      if ({dut_pc, dut_state, dut_out} !== {8'h00, 3'b000, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_state: got pc=%h st=%b out=%h expected pc=00 st=000 out=00",
                  dut_pc, dut_state, dut_out);
      end
      release_reset();
      n_checks++;
      if (dut_state !== 3'b001) begin
         n_errors++;
         $display("FAIL reset_release_fetch: got %b expected 001", dut_state);
      end
      sb.push_back('{pc: 8'h01, a: 8'h05, cyc: 2});
      sb.push_back('{pc: 8'h02, a: 8'h05, cyc: 2});
      while (sb.size() > 0) begin
         wait_instr(p, a, c, w, to);
         e = sb.pop_front();
         n_checks++;
         if (to || p !== e.pc || a !== e.a || c != e.cyc) begin
            n_errors++;
            $display("FAIL reset_prog: got pc=%h a=%h cyc=%0d to=%0b expected pc=%h a=%h cyc=%0d",
                     p, a, c, to, e.pc, e.a, e.cyc);
         end
      end
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dut_pc, dut_state, dut_out} !== {8'h00, 3'b000, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_mid_exec: got pc=%h st=%b out=%h expected pc=00 st=000 out=00",
                  dut_pc, dut_state, dut_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (dut_state !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_hold_before_edge: got %b expected 000", dut_state);
      end
      @(negedge clk);
      n_checks++;
      if (dut_state !== 3'b001 || dut_pc !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_rerelease: got st=%b pc=%h expected st=001 pc=00", dut_state, dut_pc);
      end
   endtask

   task automatic test_add_store();
      logic [7:0] p, a;
      int c, w, wb_total;
      bit to;
      exp_t e;
      begin_prog();
      mem[0] = enc(OP_LDA, 8'h05);
      mem[1] = enc(OP_LDB, 8'h03);
      mem[2] = enc(OP_ADD, 8'h00);
      mem[3] = enc(OP_STORE, 8'h00);
      mem[4] = enc(OP_JMP, 8'h04);
      release_reset();
      sb.push_back('{pc: 8'h01, a: 8'h05, cyc: 2});
      sb.push_back('{pc: 8'h02, a: 8'h05, cyc: 2});
      sb.push_back('{pc: 8'h03, a: 8'h08, cyc: 2});
      sb.push_back('{pc: 8'h04, a: 8'h08, cyc: 3});
      wb_total = 0;
      while (sb.size() > 0) begin
         wait_instr(p, a, c, w, to);
         wb_total += w;
         e = sb.pop_front();
         n_checks++;
         if (to || p !== e.pc || a !== e.a || c != e.cyc) begin
            n_errors++;
            $display("FAIL add_store_seq: got pc=%h a=%h cyc=%0d to=%0b expected pc=%h a=%h cyc=%0d",
                     p, a, c, to, e.pc, e.a, e.cyc);
         end
      end
      n_checks++;
      if (mem[3] !== enc(OP_STORE, 8'h08) || wb_total != 1) begin
         n_errors++;
         $display("FAIL add_store_wb: got mem3=%h wb=%0d expected mem3=%h wb=1",
                  mem[3], wb_total, enc(OP_STORE, 8'h08));
      end
   endtask

   task automatic test_self_mod();
      logic [7:0] p, a;
      int c, w, wb_total;
      bit to;
      exp_t e;
      begin_prog();
      mem[0] = enc(OP_LDA, 8'h66);
      mem[1] = enc(OP_STORE, 8'h00);
      mem[2] = enc(OP_JMP, 8'h02);
      release_reset();
      sb.push_back('{pc: 8'h01, a: 8'h66, cyc: 2});
      sb.push_back('{pc: 8'h02, a: 8'h66, cyc: 3});
      wb_total = 0;
      while (sb.size() > 0) begin
         wait_instr(p, a, c, w, to);
         wb_total += w;
         e = sb.pop_front();
         n_checks++;
         if (to || p !== e.pc || a !== e.a || c != e.cyc) begin
            n_errors++;
            $display("FAIL self_mod_seq: got pc=%h a=%h cyc=%0d to=%0b expected pc=%h a=%h cyc=%0d",
                     p, a, c, to, e.pc, e.a, e.cyc);
         end
      end
      n_checks++;
      if (mem[1] !== enc(OP_STORE, 8'h66) || mem[0] !== enc(OP_LDA, 8'h66) || wb_total != 1) begin
         n_errors++;
         $display("FAIL self_mod_wb: got mem1=%h mem0=%h wb=%0d expected mem1=%h mem0=%h wb=1",
                  mem[1], mem[0], wb_total, enc(OP_STORE, 8'h66), enc(OP_LDA, 8'h66));
      end
   endtask

   task automatic test_wrap_sat();
      logic [7:0] p, a;
      logic [7:0] add_exp, sub_exp;
      int c, w;
      bit to;
      exp_t e;
`ifdef SAT_ARITH_EN
      add_exp = 8'hFF;
      sub_exp = 8'h00;
`else
      add_exp = 8'h01;
      sub_exp = 8'hFF;
`endif
      begin_prog();
      mem[0] = enc(OP_LDA, 8'hFF);
      mem[1] = enc(OP_LDB, 8'h02);
      mem[2] = enc(OP_ADD, 8'h00);
      mem[3] = enc(OP_LDA, 8'h01);
      mem[4] = enc(OP_LDB, 8'h02);
      mem[5] = enc(OP_SUB, 8'h00);
      mem[6] = enc(OP_LDA, 8'h07);
      mem[7] = enc(OP_MOVB, 8'h00);
      mem[8] = enc(OP_LDA, 8'h01);
      mem[9] = enc(OP_ADD, 8'h00);
      release_reset();
      sb.push_back('{pc: 8'h01, a: 8'hFF, cyc: 2});
      sb.push_back('{pc: 8'h02, a: 8'hFF, cyc: 2});
      sb.push_back('{pc: 8'h03, a: add_exp, cyc: 2});
      sb.push_back('{pc: 8'h04, a: 8'h01, cyc: 2});
      sb.push_back('{pc: 8'h05, a: 8'h01, cyc: 2});
      sb.push_back('{pc: 8'h06, a: sub_exp, cyc: 2});
      sb.push_back('{pc: 8'h07, a: 8'h07, cyc: 2});
      sb.push_back('{pc: 8'h08, a: 8'h07, cyc: 2});
      sb.push_back('{pc: 8'h09, a: 8'h01, cyc: 2});
      sb.push_back('{pc: 8'h0A, a: 8'h08, cyc: 2});
      while (sb.size() > 0) begin
         wait_instr(p, a, c, w, to);
         e = sb.pop_front();
         n_checks++;
         if (to || p !== e.pc || a !== e.a || c != e.cyc) begin
            n_errors++;
            $display("FAIL wrap_sat: got pc=%h a=%h cyc=%0d to=%0b expected pc=%h a=%h cyc=%0d",
                     p, a, c, to, e.pc, e.a, e.cyc);
         end
      end
   endtask

   task automatic test_jump();
      logic [7:0] p, a;
      int c, w;
      bit to;
      exp_t e;
      begin_prog();
      mem[8'h00] = enc(OP_LDA, 8'h00);
      mem[8'h01] = enc(OP_JZ,  8'h40);
      mem[8'h40] = enc(OP_LDA, 8'h05);
      mem[8'h41] = enc(OP_JZ,  8'h80);
      mem[8'h42] = enc(OP_JMP, 8'h10);
      mem[8'h10] = enc(OP_LDA, 8'h07);
      release_reset();
      sb.push_back('{pc: 8'h01, a: 8'h00, cyc: 2});
      sb.push_back('{pc: 8'h40, a: 8'h00, cyc: 2});
      sb.push_back('{pc: 8'h41, a: 8'h05, cyc: 2});
      sb.push_back('{pc: 8'h42, a: 8'h05, cyc: 2});
      sb.push_back('{pc: 8'h10, a: 8'h05, cyc: 2});
      sb.push_back('{pc: 8'h11, a: 8'h07, cyc: 2});
      while (sb.size() > 0) begin
         wait_instr(p, a, c, w, to);
         e = sb.pop_front();
         n_checks++;
         if (to || p !== e.pc || a !== e.a || c != e.cyc) begin
            n_errors++;
            $display("FAIL jump: got pc=%h a=%h cyc=%0d to=%0b expected pc=%h a=%h cyc=%0d",
                     p, a, c, to, e.pc, e.a, e.cyc);
         end
      end
   endtask

   task automatic test_pc_wrap();
      logic [7:0] p, a;
      int c, w;
      bit to;
      exp_t e;
      begin_prog();
      mem[8'h00] = enc(OP_JMP, 8'hFE);
      mem[8'hFE] = enc(OP_LDA, 8'h11);
      mem[8'hFF] = enc(OP_LDA, 8'h3C);
      release_reset();
      sb.push_back('{pc: 8'hFE, a: 8'h00, cyc: 2});
      sb.push_back('{pc: 8'hFF, a: 8'h11, cyc: 2});
      sb.push_back('{pc: 8'h00, a: 8'h3C, cyc: 2});
      sb.push_back('{pc: 8'hFE, a: 8'h3C, cyc: 2});
      while (sb.size() > 0) begin
         wait_instr(p, a, c, w, to);
         e = sb.pop_front();
         n_checks++;
         if (to || p !== e.pc || a !== e.a || c != e.cyc) begin
            n_errors++;
            $display("FAIL pc_wrap: got pc=%h a=%h cyc=%0d to=%0b expected pc=%h a=%h cyc=%0d",
                     p, a, c, to, e.pc, e.a, e.cyc);
         end
      end
   endtask

   task automatic test_instr_sampled();
      begin_prog();
      mem[0] = enc(OP_LDA, 8'h21);
      mem[1] = enc(OP_LDB, 8'h00);
      release_reset();
      sb.push_back('{pc: 8'h01, a: 8'h21, cyc: 2});
      @(posedge clk);
      @(negedge clk);
      force_val = enc(OP_LDA, 8'h99);
      force_en  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      force_en  = 1'b0;
      begin
         exp_t e;
         e = sb.pop_front();
         n_checks++;
         if (dut_state !== 3'b001 || dut_pc !== e.pc || dut_out !== e.a) begin
            n_errors++;
            $display("FAIL instr_sampled: got st=%b pc=%h a=%h expected st=001 pc=%h a=%h",
                     dut_state, dut_pc, dut_out, e.pc, e.a);
         end
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      force_en  = 1'b0;
      force_val = 11'd0;
      test_reset();
      test_add_store();
      test_self_mod();
      test_wrap_sat();
      test_jump();
      test_pc_wrap();
      test_instr_sampled();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
